// File: rtl/PCIe_PKG.sv
// PCIe_PKG: shared constants and types for the PCIe Data Link Layer.
// Frame layout, sequence/LCRC widths, CRC-32 constants, tx state enum.
package PCIe_PKG;

  localparam int PCIe_TL_TLP_PACKET_SIZE  = 128;
  localparam int SEQ_W                    = 12;
  localparam int LCRC_W                   = 32;
  localparam int PCIe_DLL_TLP_PACKET_SIZE = PCIe_TL_TLP_PACKET_SIZE + SEQ_W + LCRC_W;

  localparam logic [LCRC_W-1:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [LCRC_W-1:0] CRC32_SEED = 32'hFFFFFFFF;

  typedef enum logic {
    NORMAL = 1'b0,
    REPLAY = 1'b1
  } tx_state_e;

  // Forward distance from b to a on the 12-bit sequence circle.
  function automatic logic [SEQ_W-1:0] seq_dist(input logic [SEQ_W-1:0] a,
                                                 input logic [SEQ_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/crc32_generator.sv
// crc32_generator: combinational CRC-32 over a DATA_W-bit word.
// MSB-first, polynomial 04C11DB7, seed FFFFFFFF, inverted result; the same
// arrangement the receive-side LCRC checker uses.
module crc32_generator
  import PCIe_PKG::*;
#(
  parameter int DATA_W = PCIe_TL_TLP_PACKET_SIZE
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [LCRC_W-1:0] crc_o
);

  logic [LCRC_W-1:0] crc;
  logic              fb;

  // Bit-serial shift register unrolled across the whole word
  always_comb begin
    crc = CRC32_SEED;
    fb  = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb  = crc[LCRC_W-1] ^ data_i[i];
      crc = {crc[LCRC_W-2:0], 1'b0} ^ (fb ? CRC32_POLY : '0);
    end
    crc_o = ~crc;
  end

endmodule

// File: rtl/pcie_dll_tx.sv
// pcie_dll_tx: transmit half of the PCIe Data Link Layer.
// Tags each TL TLP with a 12-bit sequence number and a 32-bit LCRC, keeps
// every sent frame in a retry buffer until it is Acked, and replays the
// unacknowledged frames after a Nak.
// Optional feature macro: PCIE_DLL_TX_REPLAY_TIMER_EN adds a replay timer
// that triggers a replay after REPLAY_TIMEOUT cycles without an Ack.
module pcie_dll_tx
  import PCIe_PKG::*;
#(
  parameter int TLP_W          = PCIe_TL_TLP_PACKET_SIZE,
  parameter int DEPTH          = 16,
  parameter int REPLAY_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tlp_valid_i,
  input  logic [TLP_W-1:0]             tlp_i,
  output logic                         tlp_ready_o,
  output logic                         tlp_valid_o,
  output logic [TLP_W+43:0]            tlp_o,
  input  logic                         tlp_ready_i,
  input  logic                         acknak_valid_i,
  input  logic                         acknak_nak_i,
  input  logic [11:0]                  acknak_seq_i,
  output logic                         dllp_err_o,
  output logic                         retrain_req_o,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o
);

  localparam int FRAME_W = TLP_W + SEQ_W + LCRC_W;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH + 1);
  localparam logic [SEQ_W-1:0] SEQ_ONE = 1;

  // Control state
  tx_state_e         state_q, state_d;
  logic [SEQ_W-1:0]  next_seq_q, next_seq_d;
  logic [SEQ_W-1:0]  acked_seq_q, acked_seq_d;
  logic [SEQ_W-1:0]  replay_seq_q, replay_seq_d;
  logic [1:0]        replay_num_q, replay_num_d;
  logic              pend_q, pend_d;
  logic              dllp_err_q, dllp_err_d;
  logic              retrain_q, retrain_d;
  logic              enter;

  // Output stage and retry buffer
  logic               out_vld_q, out_vld_d;
  logic [FRAME_W-1:0] out_data_q, out_data_d;
  logic [FRAME_W-1:0] rbuf [DEPTH];

  // Derived combinational terms
  logic [LCRC_W-1:0]  lcrc;
  logic [FRAME_W-1:0] new_frame;
  logic [SEQ_W-1:0]   outstanding;
  logic [SEQ_W-1:0]   ack_diff;
  logic [SEQ_W-1:0]   remaining;
  logic [SEQ_W-1:0]   replay_off;
  logic [SEQ_W-1:0]   replay_cur;
  logic               full, out_free, accept;
  logic               ack_ok, purge;
  logic               replay_more, replay_load, replay_done;
  logic               nak_hit, timeout_hit, trigger;

  crc32_generator #(
    .DATA_W (TLP_W)
  ) u_crc (
    .data_i (tlp_i),
    .crc_o  (lcrc)
  );

  assign new_frame = {next_seq_q, tlp_i, lcrc};

  // Sequence bookkeeping; buffer slots are the low AW bits of the sequence
  // number, so wr_ptr = next_seq and rd_ptr = acked_seq + 1 modulo DEPTH.
  assign outstanding = seq_dist(next_seq_q, acked_seq_q) - SEQ_ONE;
  assign full        = (outstanding == SEQ_W'(DEPTH));
  assign out_free    = !out_vld_q || tlp_ready_i;
  assign accept      = tlp_valid_i && tlp_ready_o;

  assign ack_diff    = seq_dist(acknak_seq_i, acked_seq_q);
  assign ack_ok      = acknak_valid_i && (ack_diff <= outstanding);
  assign purge       = ack_ok && (ack_diff != '0);

  assign next_seq_d  = next_seq_q + (accept ? SEQ_ONE : '0);
  assign acked_seq_d = ack_ok ? acknak_seq_i : acked_seq_q;
  assign remaining   = seq_dist(next_seq_d, acked_seq_d) - SEQ_ONE;

  // A purge that overtakes the replay cursor drags it forward to rd_ptr.
  assign replay_off  = seq_dist(replay_seq_q, acked_seq_q + SEQ_ONE);
  assign replay_cur  = (purge && (replay_off < ack_diff)) ? (acked_seq_d + SEQ_ONE)
                                                          : replay_seq_q;
  assign replay_more = (replay_cur != next_seq_q);
  assign replay_load = (state_q == REPLAY) && out_free && replay_more;
  assign replay_done = (state_q == REPLAY) && out_free && !replay_more;

  assign nak_hit     = ack_ok && acknak_nak_i && (remaining != '0);
  assign trigger     = nak_hit || timeout_hit;

`ifdef PCIE_DLL_TX_REPLAY_TIMER_EN
  localparam int TMR_W = $clog2(REPLAY_TIMEOUT + 1);
  logic [TMR_W-1:0] timer_q, timer_d;

  assign timeout_hit = (state_q == NORMAL) && (outstanding != '0) && !purge &&
                       (timer_q == TMR_W'(REPLAY_TIMEOUT - 1));

  // Replay timer: counts while frames wait for an Ack in NORMAL
  always_comb begin
    timer_d = timer_q;
    if (enter || purge) begin
      timer_d = '0;
    end else if ((state_q == NORMAL) && (outstanding != '0)) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  // Replay timer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (REPLAY_TIMEOUT != 0);
  assign timeout_hit        = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= NORMAL;
    else        state_q <= state_d;
  end

  // FSM next state: enter replay on trigger, finish or restart after a pass
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    enter   = 1'b0;
    case (state_q)
      NORMAL: begin
        if (trigger) begin
          state_d = REPLAY;
          enter   = 1'b1;
        end
      end
      REPLAY: begin
        if (replay_done) begin
          pend_d = 1'b0;
          if ((pend_q || trigger) && (remaining != '0)) enter   = 1'b1;
          else                                          state_d = NORMAL;
        end else if (trigger) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  // FSM output: TL may push only in NORMAL with room and a free output stage
  always_comb begin
    tlp_ready_o = (state_q == NORMAL) && !full && out_free;
  end

  // Datapath next state: replay cursor, replay counter, output stage, pulses
  always_comb begin
    replay_seq_d = replay_cur + (replay_load ? SEQ_ONE : '0);
    if (enter) replay_seq_d = acked_seq_d + SEQ_ONE;

    replay_num_d = purge ? 2'd0 : replay_num_q;
    retrain_d    = 1'b0;
    if (enter) begin
      retrain_d    = (replay_num_d == 2'd3);
      replay_num_d = replay_num_d + 2'd1;
    end

    dllp_err_d = acknak_valid_i && !ack_ok;

    out_vld_d  = out_vld_q && !tlp_ready_i;
    out_data_d = out_data_q;
    if (accept) begin
      out_vld_d  = 1'b1;
      out_data_d = new_frame;
    end else if (replay_load) begin
      out_vld_d  = 1'b1;
      out_data_d = rbuf[replay_cur[AW-1:0]];
    end
  end

  // Control and output-stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_seq_q   <= '0;
      acked_seq_q  <= '1;
      replay_seq_q <= '0;
      replay_num_q <= '0;
      pend_q       <= 1'b0;
      dllp_err_q   <= 1'b0;
      retrain_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
    end else begin
      next_seq_q   <= next_seq_d;
      acked_seq_q  <= acked_seq_d;
      replay_seq_q <= replay_seq_d;
      replay_num_q <= replay_num_d;
      pend_q       <= pend_d;
      dllp_err_q   <= dllp_err_d;
      retrain_q    <= retrain_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
    end
  end

  // Retry buffer write: every accepted frame is stored at wr_ptr
  always_ff @(posedge clk) begin
    if (accept) rbuf[next_seq_q[AW-1:0]] <= new_frame;
  end

  assign tlp_valid_o   = out_vld_q;
  assign tlp_o         = out_data_q;
  assign dllp_err_o    = dllp_err_q;
  assign retrain_req_o = retrain_q;
  assign outstanding_o = outstanding[CW-1:0];

endmodule

// File: tb/tb_pcie_dll_tx.sv
// tb_pcie_dll_tx: randomized self-checking bench for pcie_dll_tx.
// Keeps a sequence-indexed model of every frame sent and of the acked
// sequence number; the LCRC model is a polynomial long division.
module tb_pcie_dll_tx;

  localparam int TW    = 128;
  localparam int FW    = TW + 44;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tlp_valid_i;
  logic [TW-1:0] tlp_i;
  logic          tlp_ready_o;
  logic          tlp_valid_o;
  logic [FW-1:0] tlp_o;
  logic          tlp_ready_i;
  logic          acknak_valid_i;
  logic          acknak_nak_i;
  logic [11:0]   acknak_seq_i;
  logic          dllp_err_o;
  logic          retrain_req_o;
  logic [4:0]    outstanding_o;

  pcie_dll_tx #(
    .TLP_W          (TW),
    .DEPTH          (DEPTH),
    .REPLAY_TIMEOUT (1024)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tlp_valid_i    (tlp_valid_i),
    .tlp_i          (tlp_i),
    .tlp_ready_o    (tlp_ready_o),
    .tlp_valid_o    (tlp_valid_o),
    .tlp_o          (tlp_o),
    .tlp_ready_i    (tlp_ready_i),
    .acknak_valid_i (acknak_valid_i),
    .acknak_nak_i   (acknak_nak_i),
    .acknak_seq_i   (acknak_seq_i),
    .dllp_err_o     (dllp_err_o),
    .retrain_req_o  (retrain_req_o),
    .outstanding_o  (outstanding_o)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [FW-1:0] rx_q[$];
  int            retrain_cnt = 0;
  int            err_cnt = 0;
  logic [FW-1:0] model_frame [4096];
  int            m_next;
  int            m_acked;
  bit            bp_en = 1'b0;
  bit            hold_phy = 1'b0;

  // PHY-side monitor: log accepted frames and pulse outputs
  always @(negedge clk) begin
    if (rst_n) begin
      if (tlp_valid_o && tlp_ready_i) rx_q.push_back(tlp_o);
      if (retrain_req_o) retrain_cnt++;
      if (dllp_err_o) err_cnt++;
    end
  end

  // PHY ready driver, optionally random backpressure
  initial begin
    tlp_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hold_phy)   tlp_ready_i = 1'b0;
      else if (bp_en) tlp_ready_i = ($urandom_range(0, 3) != 0);
      else            tlp_ready_i = 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  // CRC-32 as the remainder of (M xor seed-on-top) * x^32 modulo P, inverted.
  function automatic logic [31:0] ref_crc(input logic [TW-1:0] d);
    logic [TW+31:0] m;
    m = {d, 32'h0};
    m[TW+31 -: 32] = m[TW+31 -: 32] ^ 32'hFFFFFFFF;
    for (int i = TW + 31; i >= 32; i--) begin
      if (m[i]) m[i -: 33] = m[i -: 33] ^ {1'b1, 32'h04C11DB7};
    end
    return ~m[31:0];
  endfunction

  function automatic logic [FW-1:0] make_frame(input int seq, input logic [TW-1:0] d);
    logic [11:0] s;
    s = seq[11:0];
    return {s, d, ref_crc(d)};
  endfunction

  function automatic int m_out();
    return (m_next - m_acked - 1 + 8192) % 4096;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n          = 1'b0;
    tlp_valid_i    = 1'b0;
    tlp_i          = '0;
    acknak_valid_i = 1'b0;
    acknak_nak_i   = 1'b0;
    acknak_seq_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_next  = 0;
    m_acked = 4095;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer n random TLPs back to back; model records each accepted one
  task automatic send_burst(input int n);
    logic [TW-1:0] d;
    int            w;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      d           = {$urandom, $urandom, $urandom, $urandom};
      tlp_valid_i = 1'b1;
      tlp_i       = d;
      w           = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!tlp_ready_o && w < 200);
      if (!tlp_ready_o) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: tlp_ready_o=%0b required 1 (seq %0d)", tlp_ready_o, m_next);
        tlp_valid_i = 1'b0;
        return;
      end
      model_frame[m_next] = make_frame(m_next, d);
      m_next = (m_next + 1) % 4096;
      @(posedge clk); #1;
    end
    tlp_valid_i = 1'b0;
  endtask

  task automatic send_acknak(input bit nak, input int seq);
    int diff;
    @(posedge clk); #1;
    acknak_valid_i = 1'b1;
    acknak_nak_i   = nak;
    acknak_seq_i   = seq[11:0];
    @(posedge clk); #1;
    acknak_valid_i = 1'b0;
    acknak_nak_i   = 1'b0;
    diff = (seq - m_acked + 4096) % 4096;
    if (diff <= m_out()) m_acked = seq;
  endtask

  task automatic wait_rx(input int target);
    int c;
    c = 0;
    while (rx_q.size() < target && c < 300) begin
      @(posedge clk);
      c++;
    end
    #1;
    if (rx_q.size() < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_timeout: received %0d frames required %0d", rx_q.size(), target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    idle(1);
    n_cmp++;
    if (tlp_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b required 1", tlp_ready_o); end
    n_cmp++;
    if (tlp_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b required 0", tlp_valid_o); end
    n_cmp++;
    if (tlp_o !== '0) begin n_bad++; $display("FAIL reset_data: got %h required 0", tlp_o); end
    n_cmp++;
    if (outstanding_o !== 5'd0) begin n_bad++; $display("FAIL reset_outstanding: got %0d required 0", outstanding_o); end
    n_cmp++;
    if (dllp_err_o !== 1'b0 || retrain_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pulses: got err=%0b retrain=%0b required 0/0", dllp_err_o, retrain_req_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int base;
    do_reset();
    base = rx_q.size();
    for (int i = 0; i < 3; i++) begin
      send_burst(1);
      n_cmp++;
      if (tlp_valid_o !== 1'b1 || tlp_o !== model_frame[i]) begin
        n_bad++;
        $display("FAIL basic_latency%0d: got v=%0b %h required v=1 %h", i, tlp_valid_o, tlp_o, model_frame[i]);
      end
    end
    wait_rx(base + 3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rx_q[base+i] !== model_frame[i]) begin
        n_bad++;
        $display("FAIL basic_frame%0d: got %h required %h", i, rx_q[base+i], model_frame[i]);
      end
    end
    n_cmp++;
    if (outstanding_o !== 5'(m_out())) begin n_bad++; $display("FAIL basic_outstanding: got %0d required %0d", outstanding_o, m_out()); end
  endtask

  task automatic test_full();
    do_reset();
    send_burst(DEPTH);
    idle(1);
    n_cmp++;
    if (tlp_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %0b required 0", tlp_ready_o); end
    n_cmp++;
    if (outstanding_o !== 5'(m_out())) begin n_bad++; $display("FAIL full_outstanding: got %0d required %0d", outstanding_o, m_out()); end
    send_acknak(1'b0, 5);
    n_cmp++;
    if (outstanding_o !== 5'(m_out())) begin n_bad++; $display("FAIL full_ack_outstanding: got %0d required %0d", outstanding_o, m_out()); end
    n_cmp++;
    if (tlp_ready_o !== 1'b1) begin n_bad++; $display("FAIL full_ack_ready: got %0b required 1", tlp_ready_o); end
  endtask

  task automatic test_nak_replay();
    int base;
    int viol;
    do_reset();
    base = rx_q.size();
    send_burst(8);
    wait_rx(base + 8);
    base = rx_q.size();
    viol = 0;
    send_acknak(1'b1, 3);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (tlp_valid_o && tlp_ready_o) viol++;
    end
    wait_rx(base + 4);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rx_q[base+i] !== model_frame[4+i]) begin
        n_bad++;
        $display("FAIL nak_replay_frame%0d: got %h required %h", i, rx_q[base+i], model_frame[4+i]);
      end
    end
    n_cmp++;
    if (viol !== 0) begin n_bad++; $display("FAIL nak_ready_low: ready high in %0d replay cycles, required 0", viol); end
    idle(2);
    n_cmp++;
    if (rx_q.size() !== base + 4) begin n_bad++; $display("FAIL nak_replay_count: got %0d frames required %0d", rx_q.size() - base, 4); end
    n_cmp++;
    if (tlp_ready_o !== 1'b1 || outstanding_o !== 5'(m_out())) begin
      n_bad++;
      $display("FAIL nak_after: got ready=%0b outstanding=%0d required 1/%0d", tlp_ready_o, outstanding_o, m_out());
    end
  endtask

  task automatic test_retrain();
    int base;
    int r0;
    bit ok;
    do_reset();
    r0   = retrain_cnt;
    base = rx_q.size();
    send_burst(3);
    wait_rx(base + 3);
    for (int k = 0; k < 4; k++) begin
      base = rx_q.size();
      send_acknak(1'b1, m_acked);
      wait_rx(base + 3);
      idle(2);
      ok = 1'b1;
      for (int i = 0; i < 3; i++) if (rx_q[base+i] !== model_frame[i]) ok = 1'b0;
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL retrain_replay%0d: replayed frames differ from seq 0..2", k); end
      n_cmp++;
      if (retrain_cnt - r0 !== ((k == 3) ? 1 : 0)) begin
        n_bad++;
        $display("FAIL retrain_pulse%0d: got %0d pulses required %0d", k, retrain_cnt - r0, (k == 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_ack_range();
    int base;
    int e0;
    do_reset();
    base = rx_q.size();
    send_burst(5);
    wait_rx(base + 5);
    e0 = err_cnt;
    send_acknak(1'b0, 100);
    idle(1);
    n_cmp++;
    if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL range_err: got %0d pulses required 1", err_cnt - e0); end
    n_cmp++;
    if (outstanding_o !== 5'(m_out()) || tlp_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL range_state: got outstanding=%0d ready=%0b required %0d/1", outstanding_o, tlp_ready_o, m_out());
    end
    send_acknak(1'b0, 4095);
    idle(1);
    n_cmp++;
    if (err_cnt - e0 !== 1 || outstanding_o !== 5'(m_out())) begin
      n_bad++;
      $display("FAIL range_noop: got err=%0d outstanding=%0d required 1/%0d", err_cnt - e0, outstanding_o, m_out());
    end
    send_acknak(1'b0, 4);
    n_cmp++;
    if (outstanding_o !== 5'(m_out())) begin n_bad++; $display("FAIL range_purge: got %0d required %0d", outstanding_o, m_out()); end
    base = rx_q.size();
    send_acknak(1'b1, 4);
    idle(10);
    n_cmp++;
    if (rx_q.size() !== base || tlp_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL range_empty_nak: got %0d frames ready=%0b required 0/1", rx_q.size() - base, tlp_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int batch;
    int bad_frames;
    int exp_seq;
    do_reset();
    bp_en      = 1'b1;
    bad_frames = 0;
    base       = rx_q.size();
    exp_seq    = 0;
    while (m_next < 4094) begin
      batch = (4094 - m_next < 8) ? (4094 - m_next) : 8;
      send_burst(batch);
      wait_rx(base + m_next);
      while (exp_seq < m_next) begin
        if (rx_q[base+exp_seq] !== model_frame[exp_seq]) bad_frames++;
        exp_seq++;
      end
      send_acknak(1'b0, (m_next + 4095) % 4096);
    end
    n_cmp++;
    if (bad_frames !== 0) begin n_bad++; $display("FAIL b2b_stream: %0d frames differ, required 0", bad_frames); end
    n_cmp++;
    if (outstanding_o !== 5'(m_out())) begin n_bad++; $display("FAIL b2b_outstanding: got %0d required %0d", outstanding_o, m_out()); end
    base = rx_q.size();
    send_burst(4);
    wait_rx(base + 4);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rx_q[base+i] !== model_frame[(4094 + i) % 4096]) begin
        n_bad++;
        $display("FAIL wrap_frame%0d: got %h required %h", i, rx_q[base+i], model_frame[(4094 + i) % 4096]);
      end
    end
    n_cmp++;
    if (outstanding_o !== 5'(m_out())) begin n_bad++; $display("FAIL wrap_outstanding: got %0d required %0d", outstanding_o, m_out()); end
    send_acknak(1'b0, 0);
    n_cmp++;
    if (outstanding_o !== 5'(m_out())) begin n_bad++; $display("FAIL wrap_ack0: got %0d required %0d", outstanding_o, m_out()); end
    send_acknak(1'b0, 1);
    n_cmp++;
    if (outstanding_o !== 5'(m_out())) begin n_bad++; $display("FAIL wrap_ack1: got %0d required %0d", outstanding_o, m_out()); end
    bp_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold_phy = 1'b1;
    idle(1);
    send_burst(1);
    idle(1);
    n_cmp++;
    if (tlp_valid_o !== 1'b1) begin n_bad++; $display("FAIL mid_hold: got valid=%0b required 1", tlp_valid_o); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tlp_valid_o !== 1'b0 || outstanding_o !== 5'd0 || tlp_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset: got valid=%0b outstanding=%0d ready=%0b required 0/0/1",
               tlp_valid_o, outstanding_o, tlp_ready_o);
    end
    hold_phy = 1'b0;
    do_reset();
  endtask

  initial begin
    rst_n          = 1'b0;
    tlp_valid_i    = 1'b0;
    tlp_i          = '0;
    acknak_valid_i = 1'b0;
    acknak_nak_i   = 1'b0;
    acknak_seq_i   = '0;
    m_next         = 0;
    m_acked        = 4095;
    test_reset();
    test_basic();
    test_full();
    test_nak_replay();
    test_retrain();
    test_ack_range();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pcie_dll_tx.md
Name: pcie_dll_tx

Overview:
- Transmit half of the PCIe Data Link Layer.
- Accepts TLPs from the Transaction Layer, prepends a 12-bit sequence number, appends a 32-bit LCRC, and forwards the frame to the Physical Layer.
- Holds every sent frame in a retry buffer until acknowledged.
- Consumes decoded Ack/Nak DLLPs from the receive side to purge acknowledged frames or replay unacknowledged ones.

Parameters:
- TLP_W, default PCIe_PKG::PCIe_TL_TLP_PACKET_SIZE: TL TLP width in bits.
- DEPTH, default 16: retry buffer entries; power of two, at most 2048.
- REPLAY_TIMEOUT, default 1024: replay timer limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- tlp_valid_i  in  1  TLP from TL is valid.
- tlp_i  in  TLP_W  TLP from TL.
- tlp_ready_o  out  1  block can accept a TL TLP.
- tlp_valid_o  out  1  DLL frame to PHY is valid.
- tlp_o  out  TLP_W+44  DLL frame {seq[11:0], tlp, lcrc[31:0]}, equal to PCIe_PKG::PCIe_DLL_TLP_PACKET_SIZE.
- tlp_ready_i  in  1  PHY accepts the frame.
- acknak_valid_i  in  1  decoded Ack/Nak DLLP valid, one-cycle pulse.
- acknak_nak_i  in  1  1 = Nak, 0 = Ack.
- acknak_seq_i  in  12  AckNak_Seq_Num.
- dllp_err_o  out  1  one-cycle pulse on an out-of-range Ack/Nak.
- retrain_req_o  out  1  one-cycle pulse on REPLAY_NUM rollover.
- outstanding_o  out  $clog2(DEPTH+1)  count of unacknowledged frames.

Behaviour:
Reset values: all outputs 0 except tlp_ready_o = 1. next_seq = 0, acked_seq = 12'hFFF, replay_num = 0, state = NORMAL, buffer pointers = 0.

Sequence arithmetic: all modulo 4096.
- outstanding = next_seq - acked_seq - 1.
- full = (outstanding == DEPTH).

LCRC:
- CRC-32 (polynomial 04C11DB7, seed FFFFFFFF, inverted output) computed over the tlp field only, matching the receiver's checker.
- Computed combinationally, then registered.

Accept path (NORMAL only):
- tlp_ready_o = (state == NORMAL) && !full && output stage free-or-draining.
- A handshake writes the full frame into the buffer at wr_ptr, then increments next_seq and wr_ptr.
- The frame appears on tlp_o the next cycle (latency 1).

PHY output:
- tlp_valid_o and tlp_o are held stable until tlp_ready_i is high.
- Back-to-back transfers are allowed with no bubble.

Ack handling:
- Valid when (acknak_seq_i - acked_seq) <= outstanding.
- acked_seq := acknak_seq_i; rd_ptr advances by the same difference.
- If the purge count is at least 1: replay_num := 0 and the replay timer resets.
- An Ack equal to acked_seq is a legal no-op.
- Out of range: ignored, dllp_err_o pulses.

Nak handling:
- Range check and purge are identical to Ack.
- Then, if outstanding after purge > 0: enter REPLAY.
- If nothing remains outstanding: no replay and replay_num is unchanged.

REPLAY state:
- tlp_ready_o = 0.
- replay_ptr starts at rd_ptr; the block resends the stored frames unmodified, in order, through the same output stage.
- After the frame at wr_ptr-1 is accepted by the PHY, return to NORMAL.
- On entry, replay_num increments. When it wraps 3 -> 0, retrain_req_o pulses and the replay still proceeds.

Simultaneous and boundary cases:
- TL accept and Ack in the same cycle: both apply. full uses the pre-update pointers.
- Ack during REPLAY: purge applies. If replay_ptr falls behind the new rd_ptr, it jumps to rd_ptr.
- Nak during REPLAY: purge applies, and a pending flag restarts replay once the current pass completes.
- Wrap-around: seq 4095 -> 0 and buffer index DEPTH-1 -> 0 are seamless.
- Reset mid-operation: everything clears immediately. Any frame in flight is dropped, and tlp_valid_o drops asynchronously.

Optional Feature:
- PCIE_DLL_TX_REPLAY_TIMER_EN defined:
  - The timer counts while outstanding > 0 and state == NORMAL.
  - It clears on a purging Ack or on replay entry.
  - At REPLAY_TIMEOUT it triggers REPLAY exactly like a Nak with no purge, including the replay_num increment.
- Undefined: no timer logic; replay occurs only on Nak.

Decomposition:
- PCIe_PKG: PCIe_DLL_TLP_PACKET_SIZE, SEQ_W = 12, LCRC_W = 32, the CRC-32 polynomial/seed constants, and the tx state enum {NORMAL, REPLAY}.
- Sub-module crc32_generator (data_i, crc_o): combinational twin of the receiver's CRC checker.
- The retry buffer is an inline register array.

Test Plan:
- Reset, then 3 TLPs with tlp_ready_i = 1 -> frames emerge with seq 0, 1, 2 one cycle after each accept, LCRC matching the reference model; outstanding_o = 3.
- DEPTH = 16: send 16 TLPs with no Ack -> tlp_ready_o = 0 at count 16. Ack seq 5 -> outstanding_o = 10, tlp_ready_o = 1.
- Send seq 0..7, Nak seq 3 -> seq 4..7 resent bit-identical, tlp_ready_o low throughout, replay_num = 1.
- Four Naks with no intervening purging Ack -> retrain_req_o pulses once, on the fourth replay entry.
- Ack seq 100 while outstanding covers 0..4 -> dllp_err_o pulses, state unchanged. Ack at seq 4095 -> 0 wrap purges correctly.
- With PCIE_DLL_TX_REPLAY_TIMER_EN and REPLAY_TIMEOUT = 50: one frame, no Ack -> replay starts at cycle 50.
